// File: rtl/bpred_resolve_queue_pkg.sv
// Shared types for the branch-resolution side of the gshare predictor:
// the per-branch prediction record and the mispredict test.
package bpred_pkg;

    localparam int GHR_W      = 11;
    localparam int BIMODAL_W  = 12;
    localparam int BTB_DATA_W = 30;

    // 88-bit record captured at fetch and consumed at resolution.
    typedef struct packed {
        logic [31:0]           pc4;
        logic                  p_dir;
        logic [31:0]           p_target;
        logic [BIMODAL_W-1:0]  bimodal;
        logic [GHR_W-1:0]      ghr;
    } bpred_rec_t;

    // A not-taken branch never mispredicts on target, only on direction.
    function automatic logic is_miss(input bpred_rec_t rec, input logic dir,
                                     input logic [31:0] target);
        return (dir != rec.p_dir) || (dir && (target != rec.p_target));
    endfunction

endpackage

// File: rtl/bpred_resolve_queue_if.sv
// Fetch-record, resolution and predictor-update bus of the resolve queue.
interface bpred_resolve_queue_if #(parameter int PTR_W = 3);
    import bpred_pkg::*;

    logic                   fetch_push;
    logic [31:0]            fetch_pc4;
    logic                   fetch_p_dir;
    logic [31:0]            fetch_p_target;
    logic [BIMODAL_W-1:0]   fetch_bimodal;
    logic [GHR_W-1:0]       fetch_ghr;
    logic                   queue_full;
    logic [PTR_W:0]         queue_count;
    logic                   exec_resolve;
    logic                   exec_dir;
    logic [31:0]            exec_target;
    logic                   stall;
    logic                   upd_valid;
    logic [31:0]            upd_pc4;
    logic [31:0]            upd_target;
    logic                   upd_dir;
    logic                   upd_miss;
    logic [BIMODAL_W-1:0]   upd_bimodal;
    logic [GHR_W-1:0]       upd_carry;
    logic [BTB_DATA_W-1:0]  upd_btb_data;
    logic                   flush;
    logic                   overflow_err;
    logic                   underflow_err;

    modport master (
        output fetch_push, fetch_pc4, fetch_p_dir, fetch_p_target, fetch_bimodal,
               fetch_ghr, exec_resolve, exec_dir, exec_target, stall,
        input  queue_full, queue_count, upd_valid, upd_pc4, upd_target, upd_dir,
               upd_miss, upd_bimodal, upd_carry, upd_btb_data, flush,
               overflow_err, underflow_err
    );

    modport slave (
        input  fetch_push, fetch_pc4, fetch_p_dir, fetch_p_target, fetch_bimodal,
               fetch_ghr, exec_resolve, exec_dir, exec_target, stall,
        output queue_full, queue_count, upd_valid, upd_pc4, upd_target, upd_dir,
               upd_miss, upd_bimodal, upd_carry, upd_btb_data, flush,
               overflow_err, underflow_err
    );

endinterface

// File: rtl/bpred_rec_fifo.sv
// Circular FIFO of prediction records with push/pop and a clear that
// drops every stored record (and any same-cycle push).
module bpred_rec_fifo
    import bpred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic           clear,
    input  bpred_rec_t     wdata,
    output bpred_rec_t     rdata,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    bpred_rec_t     mem_q [DEPTH];
    bpred_rec_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == (PTR_W+1)'(0));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state pointers, occupancy and storage; clear wins over push/pop.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s) && !clear;
        if (clear) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = (PTR_W+1)'(0);
        end else begin
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push_ok_s) - (PTR_W+1)'(pop_ok_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= (PTR_W+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bpred_resolve_queue.sv
// Execute-side resolve queue: matches resolved branches against the oldest
// fetch prediction, drives the predictor update bus and flushes on a miss.
module bpred_resolve_queue
    import bpred_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    bpred_resolve_queue_if.slave  bus
);

    bpred_rec_t     fetch_rec_s, head_s;
    logic           full_s, empty_s, pop_s, miss_s, clear_s;
    logic [PTR_W:0] count_s;

    logic                  upd_valid_q, upd_valid_d, upd_dir_q, upd_dir_d;
    logic                  upd_miss_q, upd_miss_d, flush_q, flush_d;
    logic [31:0]           upd_pc4_q, upd_pc4_d, upd_target_q, upd_target_d;
    logic [BIMODAL_W-1:0]  upd_bimodal_q, upd_bimodal_d;
    logic [GHR_W-1:0]      upd_carry_q, upd_carry_d;
    logic [BTB_DATA_W-1:0] upd_btb_data_q, upd_btb_data_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;

    // Resolution qualifiers; a stalled resolve is simply not seen.
    always_comb begin
        fetch_rec_s = '{pc4: bus.fetch_pc4, p_dir: bus.fetch_p_dir,
                        p_target: bus.fetch_p_target,
                        bimodal: bus.fetch_bimodal, ghr: bus.fetch_ghr};
        pop_s   = bus.exec_resolve && !bus.stall && !empty_s;
        miss_s  = is_miss(head_s, bus.exec_dir, bus.exec_target);
        clear_s = pop_s && miss_s;
    end

    bpred_rec_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.fetch_push),
        .pop   (pop_s),
        .clear (clear_s),
        .wdata (fetch_rec_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Update bus loads only on a pop; payload holds between strobes.
    always_comb begin
        upd_valid_d    = pop_s;
        flush_d        = clear_s;
        upd_pc4_d      = upd_pc4_q;
        upd_target_d   = upd_target_q;
        upd_dir_d      = upd_dir_q;
        upd_miss_d     = upd_miss_q;
        upd_bimodal_d  = upd_bimodal_q;
        upd_carry_d    = upd_carry_q;
        upd_btb_data_d = upd_btb_data_q;
        if (pop_s) begin
            upd_pc4_d      = head_s.pc4;
            upd_target_d   = bus.exec_target;
            upd_dir_d      = bus.exec_dir;
            upd_miss_d     = miss_s;
            upd_bimodal_d  = head_s.bimodal;
            upd_carry_d    = head_s.ghr;
            upd_btb_data_d = bus.exec_target[31:2];
        end else begin
            upd_miss_d     = upd_miss_q;
        end
        overflow_d  = overflow_q  || (bus.fetch_push && full_s && !pop_s);
        underflow_d = underflow_q || (bus.exec_resolve && !bus.stall && empty_s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_q    <= 1'b0;
            flush_q        <= 1'b0;
            upd_pc4_q      <= 32'd0;
            upd_target_q   <= 32'd0;
            upd_dir_q      <= 1'b0;
            upd_miss_q     <= 1'b0;
            upd_bimodal_q  <= '0;
            upd_carry_q    <= '0;
            upd_btb_data_q <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            upd_valid_q    <= upd_valid_d;
            flush_q        <= flush_d;
            upd_pc4_q      <= upd_pc4_d;
            upd_target_q   <= upd_target_d;
            upd_dir_q      <= upd_dir_d;
            upd_miss_q     <= upd_miss_d;
            upd_bimodal_q  <= upd_bimodal_d;
            upd_carry_q    <= upd_carry_d;
            upd_btb_data_q <= upd_btb_data_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.queue_full    = full_s;
    assign bus.queue_count   = count_s;
    assign bus.upd_valid     = upd_valid_q;
    assign bus.upd_pc4       = upd_pc4_q;
    assign bus.upd_target    = upd_target_q;
    assign bus.upd_dir       = upd_dir_q;
    assign bus.upd_miss      = upd_miss_q;
    assign bus.upd_bimodal   = upd_bimodal_q;
    assign bus.upd_carry     = upd_carry_q;
    assign bus.upd_btb_data  = upd_btb_data_q;
    assign bus.flush         = flush_q;
    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Directed bench: stimulus queues the expected update for each resolve, a
// negedge monitor checks every update strobe against that queue.
module tb_bpred_resolve_queue;
    import bpred_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] target;
        logic        dir;
        logic        miss;
        logic [11:0] bimodal;
        logic [10:0] carry;
        logic [29:0] btb;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    bpred_resolve_queue_if #(.PTR_W(PTR_W)) bus ();

    bpred_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.upd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_upd: got upd_valid=1, expected 0 (pc4=0x%0h)", bus.upd_pc4);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("upd_pc4", bus.upd_pc4, e.pc4);
                    check("upd_target", bus.upd_target, e.target);
                    check("upd_dir", 32'(bus.upd_dir), 32'(e.dir));
                    check("upd_miss", 32'(bus.upd_miss), 32'(e.miss));
                    check("flush", 32'(bus.flush), 32'(e.miss));
                    check("upd_bimodal", 32'(bus.upd_bimodal), 32'(e.bimodal));
                    check("upd_carry", 32'(bus.upd_carry), 32'(e.carry));
                    check("upd_btb_data", 32'(bus.upd_btb_data), 32'(e.btb));
                end
            end else if (bus.flush) begin
                check("flush_without_upd", 32'(bus.flush), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_push = 1'b0;
        bus.exec_resolve = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc4, input logic pd, input logic [31:0] pt,
                            input logic [11:0] bim, input logic [10:0] ghr);
        bus.fetch_push = 1'b1;
        bus.fetch_pc4 = pc4;
        bus.fetch_p_dir = pd;
        bus.fetch_p_target = pt;
        bus.fetch_bimodal = bim;
        bus.fetch_ghr = ghr;
    endtask

    // Drive a resolve; when a pop is expected, queue the hand-derived update.
    task automatic set_resolve(input logic dir, input logic [31:0] tgt, input logic expect_pop,
                               input logic [31:0] pc4, input logic miss,
                               input logic [11:0] bim, input logic [10:0] ghr);
        exp_t e;
        bus.exec_resolve = 1'b1;
        bus.exec_dir = dir;
        bus.exec_target = tgt;
        if (expect_pop) begin
            e = '{pc4: pc4, target: tgt, dir: dir, miss: miss, bimodal: bim,
                  carry: ghr, btb: tgt[31:2]};
            exp_q.push_back(e);
        end
    endtask

    function automatic logic rec_dir(input int i);
        return (i != 5);
    endfunction

    initial begin
        bus.fetch_pc4 = 32'd0; bus.fetch_p_dir = 1'b0; bus.fetch_p_target = 32'd0;
        bus.fetch_bimodal = 12'd0; bus.fetch_ghr = 11'd0;
        bus.exec_dir = 1'b0; bus.exec_target = 32'd0;
        idle();
        cyc(); cyc();
        reset = 1'b0;
        check("rst_count", 32'(bus.queue_count), 32'd0);
        check("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        check("rst_flush", 32'(bus.flush), 32'd0);
        check("rst_upd_pc4", bus.upd_pc4, 32'd0);
        check("rst_full", 32'(bus.queue_full), 32'd0);
        check("rst_errs", {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);

        // 1: single hit
        set_push(32'h104, 1'b1, 32'h200, 12'h5A3, 11'h6D5); cyc(); idle();
        check("t1_count_push", 32'(bus.queue_count), 32'd1);
        set_resolve(1'b1, 32'h200, 1'b1, 32'h104, 1'b0, 12'h5A3, 11'h6D5); cyc(); idle();
        check("t1_upd_valid", 32'(bus.upd_valid), 32'd1);
        check("t1_btb", 32'(bus.upd_btb_data), 32'h80);
        check("t1_count", 32'(bus.queue_count), 32'd0);

        // 2: direction miss flushes, same-edge push is dropped
        for (int i = 0; i < 3; i++) begin
            set_push(32'h110 + 32'(16*i), 1'b0, 32'h0, 12'h011 + 12'(i), 11'h022 + 11'(i)); cyc();
        end
        idle();
        check("t2_count3", 32'(bus.queue_count), 32'd3);
        set_push(32'h140, 1'b1, 32'h500, 12'h0AA, 11'h055);
        set_resolve(1'b1, 32'h40, 1'b1, 32'h110, 1'b1, 12'h011, 11'h022); cyc(); idle();
        check("t2_flush", 32'(bus.flush), 32'd1);
        check("t2_count_after_flush", 32'(bus.queue_count), 32'd0);
        cyc();
        check("t2_flush_one_cycle", 32'(bus.flush), 32'd0);
        check("t2_upd_valid_low", 32'(bus.upd_valid), 32'd0);
        check("t2_upd_target_held", bus.upd_target, 32'h40);
        check("t2_no_overflow", 32'(bus.overflow_err), 32'd0);

        // 3: taken, direction right, target wrong
        set_push(32'h300, 1'b1, 32'h200, 12'h123, 11'h321); cyc(); idle();
        set_resolve(1'b1, 32'h204, 1'b1, 32'h300, 1'b1, 12'h123, 11'h321); cyc(); idle();
        check("t3_flush", 32'(bus.flush), 32'd1);
        check("t3_count", 32'(bus.queue_count), 32'd0);

        // 4: fill to DEPTH, overflow on the ninth push
        for (int i = 0; i < 9; i++) begin
            set_push(32'h1000 + 32'(4*i), rec_dir(i), 32'h2000 + 32'(16*i),
                     12'h100 + 12'(i), 11'h040 + 11'(i));
            cyc();
            if (i == 7) begin
                check("t4_full", 32'(bus.queue_full), 32'd1);
                check("t4_no_ovf_yet", 32'(bus.overflow_err), 32'd0);
            end
        end
        idle();
        check("t4_count8", 32'(bus.queue_count), 32'd8);
        check("t4_overflow", 32'(bus.overflow_err), 32'd1);
        set_push(32'h1024, rec_dir(9), 32'h2090, 12'h109, 11'h049);
        set_resolve(1'b1, 32'h2000, 1'b1, 32'h1000, 1'b0, 12'h100, 11'h040); cyc(); idle();
        check("t4_count_pushpop_full", 32'(bus.queue_count), 32'd8);
        check("t4_overflow_sticky", 32'(bus.overflow_err), 32'd1);

        // 5: stalled resolve is ignored, then one update when stall drops
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1; bus.exec_resolve = 1'b1;
            bus.exec_dir = 1'b1; bus.exec_target = 32'h2010;
            cyc();
            check("t5_count_stalled", 32'(bus.queue_count), 32'd8);
        end
        bus.stall = 1'b0;
        set_resolve(1'b1, 32'h2010, 1'b1, 32'h1004, 1'b0, 12'h101, 11'h041); cyc(); idle();
        check("t5_count7", 32'(bus.queue_count), 32'd7);
        cyc();

        // drain: record 5 is a not-taken hit with an unrelated target
        for (int i = 2; i < 8; i++) begin
            if (i == 5)
                set_resolve(1'b0, 32'hDEAD0000, 1'b1, 32'h1014, 1'b0, 12'h105, 11'h045);
            else
                set_resolve(1'b1, 32'h2000 + 32'(16*i), 1'b1, 32'h1000 + 32'(4*i), 1'b0,
                            12'h100 + 12'(i), 11'h040 + 11'(i));
            cyc();
        end
        set_resolve(1'b1, 32'h2090, 1'b1, 32'h1024, 1'b0, 12'h109, 11'h049); cyc(); idle();
        check("drain_count", 32'(bus.queue_count), 32'd0);

        // 6: underflow, then empty+push+resolve keeps the pushed record
        check("t6_no_underflow_yet", 32'(bus.underflow_err), 32'd0);
        set_resolve(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 12'h0, 11'h0); cyc(); idle();
        check("t6_underflow", 32'(bus.underflow_err), 32'd1);
        check("t6_upd_valid", 32'(bus.upd_valid), 32'd0);
        set_push(32'h600, 1'b1, 32'h700, 12'h0F0, 11'h00F);
        set_resolve(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 12'h0, 11'h0); cyc(); idle();
        check("t6_count_empty_pushpop", 32'(bus.queue_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_push(32'h610 + 32'(4*i), 1'b1, 32'h710, 12'h0F1, 11'h010); cyc();
        end
        idle();
        check("t6_count4", 32'(bus.queue_count), 32'd4);
        reset = 1'b1;
        bus.exec_resolve = 1'b1; bus.exec_dir = 1'b1; bus.exec_target = 32'h700;
        cyc(); idle();
        reset = 1'b0;
        check("t6_rst_count", 32'(bus.queue_count), 32'd0);
        check("t6_rst_errs", {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);
        check("t6_rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        cyc(); cyc();
        check("t6_count_after_rst", 32'(bus.queue_count), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
